// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 2**N:1 mux: walks sel across every channel,
// assembles one bit per channel into a word, and hands it off with valid/ready.
module mux_scan_ctrl #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont,
  input  logic                y_in,
  output logic [N-1:0]        sel,
  output logic                busy,
  output logic [(1<<N)-1:0]   data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic [7:0]          scan_count
);

  localparam int CH = 1 << N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q;
  logic [N-1:0]    sel_q;
  logic            busy_q;
  logic [CH-1:0]   data_out_q;
  logic            data_valid_q;
  logic [7:0]      scan_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      scan_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
            sel_q   <= '0;
          end
        end
        SCAN: begin
          // y_in reflects the current sel, so capture before advancing
          data_out_q[sel_q] <= y_in;
          if (sel_q == {N{1'b1}}) begin
            state_q      <= HOLD;
            sel_q        <= '0;
            data_valid_q <= 1'b1;
          end else begin
            sel_q <= sel_q + 1'b1;
          end
        end
        HOLD: begin
          if (data_ready) begin
            data_valid_q <= 1'b0;
            scan_count_q <= scan_count_q + 8'd1;
            sel_q        <= '0;
            if (cont) begin
              state_q <= SCAN;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          sel_q        <= '0;
          data_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign scan_count = scan_count_q;

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: N, default 3, select width; channel count is 2**N.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request one scan; sampled only in IDLE.
REQ-005 Port: cont  input  1  continuous mode; sampled at each handshake in HOLD.
REQ-006 Port: y_in  input  1  output of the downstream 2**N:1 mux; combinational from sel.
REQ-007 Port: sel  output  N  channel select driven to the mux; registered.
REQ-008 Port: busy  output  1  high in SCAN and HOLD.
REQ-009 Port: data_out  output  2**N  captured word; data_out[i] = y_in sampled while sel == i.
REQ-010 Port: data_valid  output  1  data_out holds a complete, unaccepted word.
REQ-011 Port: data_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-012 Port: scan_count  output  8  number of words accepted; wraps modulo 256.

Function
REQ-013 FSM states SHALL be IDLE, SCAN, HOLD; the encoding is free.
REQ-014 IDLE: sel = 0, busy = 0, data_valid = 0. Start = 1 at an edge moves the FSM to SCAN with sel = 0.
REQ-015 SCAN: each edge SHALL store y_in into data_out[sel] and then increment sel by 1.
REQ-016 SCAN: the edge that samples sel = 2**N-1 SHALL move the FSM to HOLD, set sel = 0 and set data_valid = 1.
REQ-017 Latency SHALL be fixed: data_valid rises exactly 2**N rising edges after the edge that accepted start.
REQ-018 In SCAN, sel SHALL step through 0..2**N-1 in order with no repeats, skips or idle cycles.
REQ-019 HOLD: data_out and data_valid SHALL stay stable until data_valid & data_ready is high at an edge.
REQ-020 Handshake edge in HOLD with cont = 1: go to SCAN, sel = 0, data_valid = 0 (back-to-back scans).
REQ-021 Handshake edge in HOLD with cont = 0: go to IDLE, data_valid = 0.
REQ-022 Each handshake edge SHALL increment scan_count by 1; 255 wraps to 0.
REQ-023 Start SHALL be ignored in SCAN and HOLD, and SHALL NOT be queued.
REQ-024 data_ready while data_valid = 0 SHALL have no effect.
REQ-025 Data_out bits not yet rewritten in the current scan SHALL keep their previous-scan values until overwritten.
REQ-026 No combinational path SHALL exist from any input to any output.

Reset
REQ-027 When rst = 1 at an edge: FSM = IDLE, sel = 0, busy = 0, data_valid = 0, data_out = 0, scan_count = 0.
REQ-028 Reset SHALL take priority over start, data_ready and any in-progress scan.
REQ-029 Reset mid-SCAN or mid-HOLD SHALL discard the partial or held word, and no handshake SHALL be counted.

Verification
REQ-030 Basic scan, N = 3: mux in[0:7] = 8'b10101100, pulse start, data_ready = 1, cont = 0.
  -> sel steps 0..7; data_valid rises 8 edges after start; data_out = 8'h35; scan_count = 1; returns to IDLE.
REQ-031 Backpressure: same stimulus with data_ready = 0 for 5 cycles after data_valid.
  -> data_out = 8'h35 and data_valid = 1 stay stable; sel = 0; one handshake when data_ready rises.
REQ-032 Continuous mode: cont = 1, data_ready = 1, mux input changed to 8'hFF after the first word.
  -> back-to-back words 8'h35 then 8'hFF; one idle sel = 0 cycle between scans; scan_count increments per word.
REQ-033 Ignored start: start held high during SCAN and HOLD with cont = 0.
  -> exactly one scan; FSM returns to IDLE; a new scan begins on the next edge only if start is still high in IDLE.
REQ-034 Reset mid-scan: rst asserted when sel = 4.
  -> next edge: sel = 0, busy = 0, data_out = 0, data_valid = 0, scan_count unchanged from 0.
REQ-035 Counter wrap: 256 accepted words.
  -> scan_count reads 0 after the 256th handshake.
